// File: rtl/int8_simd_dot_unit.sv
// rtl/int8_simd_dot_unit.sv - two-stage pipelined INT8 SIMD dot-product / MAC unit
//
// Purpose:
//   Treats each XLEN operand as LANES = XLEN/8 signed INT8 lanes (lane0 = bits 7:0).
//   S1 forms the per-lane 8x8 -> 16-bit signed products. S2 reduces them and
//   applies the op-specific wrap/saturate/clip. Valid/ready on both sides,
//   1 op/cycle sustained, 2-cycle latency when unstalled.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   in_valid_i / in_ready_o    issue-side handshake
//   op_i                       00 DOT8, 01 DOT8_SAT, 10 VMAC8, 11 DOT8_CLIP
//   rs1_i, rs2_i               packed INT8 lane operands
//   rd_i                       accumulator (XLEN scalar or packed INT8 lanes for VMAC8)
//   rd_addr_i, tag_i           sideband carried with the op
//   out_valid_o / out_ready_i  writeback-side handshake
//   result_o, sat_o            result and "some clamp happened" flag
//   rd_addr_o, tag_o           sideband of the presented result

module int8_simd_dot_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  rd_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic             sat_o,
    output logic [4:0]       rd_addr_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int LANES = XLEN / 8;
    // Lane-sum width: 16-bit products plus growth for the adder tree.
    localparam int SW    = 16 + $clog2(LANES);
    // Accumulate width: two guard bits so sext(S) + rd never overflows.
    localparam int TW    = XLEN + 2;

    localparam logic signed [TW-1:0] SAT_MAX  = {3'b000, {(XLEN-1){1'b1}}};
    localparam logic signed [TW-1:0] SAT_MIN  = {3'b111, {(XLEN-1){1'b0}}};
    localparam logic signed [TW-1:0] CLIP_MAX = {{(TW-8){1'b0}}, 8'h7F};
    localparam logic signed [TW-1:0] CLIP_MIN = {{(TW-8){1'b1}}, 8'h80};
    localparam logic signed [16:0]   LANE_MAX = 17'sd127;
    localparam logic signed [16:0]   LANE_MIN = -17'sd128;

    typedef enum logic [1:0] {
        OP_DOT8      = 2'b00,
        OP_DOT8_SAT  = 2'b01,
        OP_VMAC8     = 2'b10,
        OP_DOT8_CLIP = 2'b11
    } op_e;

    // Stage 1 registers
    logic                s1_v_q;
    logic [16*LANES-1:0] s1_prod_q;
    op_e                 s1_op_q;
    logic [XLEN-1:0]     s1_rd_q;
    logic [4:0]          s1_addr_q;
    logic [TAG_W-1:0]    s1_tag_q;

    // Stage 2 (output) registers
    logic                s2_v_q;
    logic [XLEN-1:0]     s2_res_q;
    logic                s2_sat_q;
    logic [4:0]          s2_addr_q;
    logic [TAG_W-1:0]    s2_tag_q;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv     = !s2_v_q || out_ready_i;
    assign s1_adv     = !s1_v_q || s2_adv;
    assign in_ready_o = s1_adv;
    assign accept     = in_valid_i && s1_adv;

    // S1: per-lane products. Operands are sign-extended to 16 bits first so
    // the low 16 bits of the 16x16 product are the exact 8x8 signed product.
    logic [16*LANES-1:0] prod_d;
    logic signed [15:0]  mul_a;
    logic signed [15:0]  mul_b;
    logic signed [15:0]  mul_p;

    always_comb begin
        prod_d = '0;
        mul_a  = '0;
        mul_b  = '0;
        mul_p  = '0;
        for (int i = 0; i < LANES; i++) begin
            mul_a = {{8{rs1_i[8*i+7]}}, rs1_i[8*i +: 8]};
            mul_b = {{8{rs2_i[8*i+7]}}, rs2_i[8*i +: 8]};
            mul_p = mul_a * mul_b;
            prod_d[16*i +: 16] = mul_p;
        end
    end

    // S2: reduction, accumulate and clamp.
    logic signed [SW-1:0] sum;
    logic signed [TW-1:0] t_acc;
    logic signed [15:0]   lane_p;
    logic [7:0]           lane_rd;
    logic signed [16:0]   lane_v;
    logic [XLEN-1:0]      vmac_res;
    logic                 vmac_sat;
    logic [XLEN-1:0]      res_d;
    logic                 sat_d;

    always_comb begin
        sum      = '0;
        lane_p   = '0;
        lane_rd  = '0;
        lane_v   = '0;
        vmac_res = '0;
        vmac_sat = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_p  = s1_prod_q[16*i +: 16];
            sum     = sum + {{(SW-16){lane_p[15]}}, lane_p};
            lane_rd = s1_rd_q[8*i +: 8];
            lane_v  = {lane_p[15], lane_p} + {{9{lane_rd[7]}}, lane_rd};
            if (lane_v > LANE_MAX) begin
                vmac_res[8*i +: 8] = 8'h7F;
                vmac_sat           = 1'b1;
            end else if (lane_v < LANE_MIN) begin
                vmac_res[8*i +: 8] = 8'h80;
                vmac_sat           = 1'b1;
            end else begin
                vmac_res[8*i +: 8] = lane_v[7:0];
            end
        end
        t_acc = {{(TW-SW){sum[SW-1]}}, sum} + {{2{s1_rd_q[XLEN-1]}}, s1_rd_q};

        res_d = t_acc[XLEN-1:0];
        sat_d = 1'b0;
        case (s1_op_q)
            OP_DOT8: begin
                res_d = t_acc[XLEN-1:0];
            end
            OP_DOT8_SAT: begin
                if (t_acc > SAT_MAX) begin
                    res_d = SAT_MAX[XLEN-1:0];
                    sat_d = 1'b1;
                end else if (t_acc < SAT_MIN) begin
                    res_d = SAT_MIN[XLEN-1:0];
                    sat_d = 1'b1;
                end
            end
            OP_DOT8_CLIP: begin
                // In-range values are already sign-extended within t_acc.
                if (t_acc > CLIP_MAX) begin
                    res_d = CLIP_MAX[XLEN-1:0];
                    sat_d = 1'b1;
                end else if (t_acc < CLIP_MIN) begin
                    res_d = CLIP_MIN[XLEN-1:0];
                    sat_d = 1'b1;
                end
            end
            OP_VMAC8: begin
                res_d = vmac_res;
                sat_d = vmac_sat;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_v_q    <= 1'b0;
            s1_prod_q <= '0;
            s1_op_q   <= OP_DOT8;
            s1_rd_q   <= '0;
            s1_addr_q <= '0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_res_q  <= '0;
            s2_sat_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_tag_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_v_q <= in_valid_i;
            end
            if (accept) begin
                s1_prod_q <= prod_d;
                s1_op_q   <= op_e'(op_i);
                s1_rd_q   <= rd_i;
                s1_addr_q <= rd_addr_i;
                s1_tag_q  <= tag_i;
            end
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
            end
            // Payload only moves with a real op so outputs hold while stalled.
            if (s2_adv && s1_v_q) begin
                s2_res_q  <= res_d;
                s2_sat_q  <= sat_d;
                s2_addr_q <= s1_addr_q;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    assign out_valid_o = s2_v_q;
    assign result_o    = s2_res_q;
    assign sat_o       = s2_sat_q;
    assign rd_addr_o   = s2_addr_q;
    assign tag_o       = s2_tag_q;

endmodule

// File: tb/tb_int8_simd_dot_unit.sv
// tb/tb_int8_simd_dot_unit.sv - scoreboard testbench for int8_simd_dot_unit

module tb_int8_simd_dot_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [XLEN-1:0]  rs1, rs2, rd;
    logic [4:0]       rd_addr;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic             sat;
    logic [4:0]       rd_addr_out;
    logic [TAG_W-1:0] tag_out;

    always #5 clk = ~clk;

    int_dummy_guard: assert property (@(posedge clk) 1'b1);

    int8_simd_dot_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .rd_i        (rd),
        .rd_addr_i   (rd_addr),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .sat_o       (sat),
        .rd_addr_o   (rd_addr_out),
        .tag_o       (tag_out)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        sat;
        logic [4:0]  addr;
        logic [7:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic rand_ready = 1'b0;

    // Reference model: plain integer arithmetic on the lane values.
    function automatic logic [32:0] model(input logic [1:0] f_op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] r);
        longint s, t, lx, ly, lr, lane;
        byte x, y, rb;
        logic [31:0] res;
        logic sr;
        s = 0; res = '0; sr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = a[8*i +: 8]; y = b[8*i +: 8]; rb = r[8*i +: 8];
            lx = x; ly = y; lr = rb;
            s = s + lx * ly;
            lane = lx * ly + lr;
            if (lane > 127) begin res[8*i +: 8] = 8'h7F; if (f_op == 2'b10) sr = 1'b1; end
            else if (lane < -128) begin res[8*i +: 8] = 8'h80; if (f_op == 2'b10) sr = 1'b1; end
            else res[8*i +: 8] = lane[7:0];
        end
        t = s + longint'($signed(r));
        case (f_op)
            2'b00: res = t[31:0];
            2'b01: begin
                if (t > 64'sd2147483647) begin res = 32'h7FFFFFFF; sr = 1'b1; end
                else if (t < -64'sd2147483648) begin res = 32'h80000000; sr = 1'b1; end
                else res = t[31:0];
            end
            2'b11: begin
                if (t > 127) begin res = 32'h0000007F; sr = 1'b1; end
                else if (t < -128) begin res = 32'hFFFFFF80; sr = 1'b1; end
                else res = t[31:0];
            end
            default: ;
        endcase
        return {sr, res};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [4:0] addr, input logic [7:0] f_tag,
                        input bit use_exp, input logic [31:0] e_res, input logic e_sat);
        exp_t e;
        logic [32:0] m;
        bit done;
        m = model(f_op, a, b, r);
        e.res  = use_exp ? e_res : m[31:0];
        e.sat  = use_exp ? e_sat : m[32];
        e.addr = addr;
        e.tag  = f_tag;
        op = f_op; rs1 = a; rs2 = b; rd = r; rd_addr = addr; tag = f_tag;
        in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0 for tag %h", f_tag);
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops and compares on every output transfer, checks hold during stalls.
    exp_t held, act_m, e_m;
    bit   held_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            act_m = {result, sat, rd_addr_out, tag_out};
            if (held_v) begin
                n_vec++;
                if (!out_valid || act_m !== held) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%b %h expected v=1 %h", out_valid, act_m, held);
                end
            end
            held_v = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_result: got %h expected no output", act_m);
                    end else begin
                        e_m = sb.pop_front();
                        if (act_m !== e_m) begin
                            n_err++;
                            $display("FAIL result tag=%h: got res=%h sat=%b addr=%0d tag=%h expected res=%h sat=%b addr=%0d tag=%h",
                                     e_m.tag, result, sat, rd_addr_out, tag_out, e_m.res, e_m.sat, e_m.addr, e_m.tag);
                        end
                    end
                end else begin
                    held   = act_m;
                    held_v = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [7:0] rbyte();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'h81;
            3: return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rword();
        return {rbyte(), rbyte(), rbyte(), rbyte()};
    endfunction

    function automatic logic [31:0] racc();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'($urandom_range(0, 400)) - 32'd200;
            3: return 32'h7FFF0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
        rd_addr = '0; tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_outputs", 64'({result, sat, rd_addr_out, tag_out}), 64'd0);
        @(posedge clk); #1;

        // Directed: DOT8 and two-cycle latency.
        send(2'b00, 32'h01020304, 32'h05060708, 32'd10, 5'd1, 8'h11, 1, 32'h00000050, 1'b0);
        in_valid = 1'b0;
        @(negedge clk); chk("latency_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("latency_cycle2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        drain(50);

        // Directed: wrap/saturate, VMAC8 clamps, CLIP boundaries.
        send(2'b00, 32'h80808080, 32'h80808080, 32'h7FFFFFFF, 5'd2, 8'h21, 1, 32'h8000FFFF, 1'b0);
        send(2'b01, 32'h80808080, 32'h80808080, 32'h7FFFFFFF, 5'd3, 8'h22, 1, 32'h7FFFFFFF, 1'b1);
        send(2'b10, 32'h7F7F0102, 32'h7F810304, 32'h00000A05, 5'd4, 8'h23, 1, 32'h7F800D0D, 1'b1);
        send(2'b11, 32'h00000010, 32'h00000010, 32'h00000000, 5'd5, 8'h24, 1, 32'h0000007F, 1'b1);
        send(2'b11, 32'h00000010, 32'h00000010, 32'hFFFFFE80, 5'd6, 8'h25, 1, 32'hFFFFFF80, 1'b0);
        send(2'b10, 32'h00000040, 32'h00000002, 32'h000000FF, 5'd7, 8'h26, 1, 32'h0000007F, 1'b0);
        in_valid = 1'b0;
        drain(50);

        // Back-to-back with a three-cycle output stall.
        fork
            begin
                for (int k = 1; k <= 4; k++)
                    send(2'b00, rword(), rword(), racc(), 5'(k), 8'(k), 0, '0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                chk("stall_first_result_seen", 64'(seen), 64'd1);
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready_low", 64'(in_ready), 64'd0);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain(50);

        // Reset with both stages occupied discards everything.
        out_ready = 1'b0;
        send(2'b00, 32'h01010101, 32'h01010101, 32'd0, 5'd8, 8'hA1, 0, '0, 1'b0);
        send(2'b00, 32'h02020202, 32'h01010101, 32'd0, 5'd9, 8'hA2, 0, '0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_out_valid", 64'(out_valid), 64'd0);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        chk("post_reset_result", 64'(result), 64'd0);
        repeat (8) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            send(2'($urandom), rword(), rword(), racc(), 5'($urandom), 8'($urandom), 0, '0, 1'b0);
        end
        in_valid = 1'b0;
        drain(2000);
        rand_ready = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
